// File: rtl/pipelined_sync_ram_pkg.sv
// Shared constants and byte helpers for pipelined_sync_ram.
package pipelined_sync_ram_pkg;

    localparam int MAX_READ_LATENCY = 4;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/pipelined_sync_ram_sync_fifo.sv
// Response buffer: synchronous FIFO; output reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_push = push & (count != CW'(DEPTH));
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : store[rd_ptr];

endmodule

// File: rtl/pipelined_sync_ram.sv
// Single-port RAM with credit-controlled read pipeline and response FIFO.
// Optional per-byte even parity with rsp_err when RAM_PARITY_EN is defined.
module pipelined_sync_ram
    import pipelined_sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata
`ifdef RAM_PARITY_EN
    ,
    output logic                    rsp_err
`endif
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int WORDS = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
`ifdef RAM_PARITY_EN
    localparam int FW    = DATA_WIDTH + 1;
`else
    localparam int FW    = DATA_WIDTH;
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
        (DATA_WIDTH % 8) != 0 || RSP_DEPTH < 1) begin : g_bad_cfg
        $error("pipelined_sync_ram: illegal parameter combination");
    end

    logic                  acc, acc_rd, acc_wr, rsp_pop;
    logic [CW-1:0]         credits;
    logic                  cred_init;
    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DATA_WIDTH-1:0] rd_word, wr_word;
    logic                  vld_p0;
    logic [FW-1:0]         dat_p0;
    logic                  push_vld;
    logic [FW-1:0]         push_dat;
    logic [FW-1:0]         fifo_dout;
    logic                  fifo_empty;

    assign acc     = req_valid & req_ready;
    assign acc_rd  = acc & ~req_we;
    assign acc_wr  = acc & req_we;
    assign rsp_pop = rsp_valid & rsp_ready;

    // Credits start at zero under reset so req_ready stays low until the first live edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits   <= '0;
            cred_init <= 1'b0;
        end else if (!cred_init) begin
            credits   <= CW'(RSP_DEPTH);
            cred_init <= 1'b1;
        end else begin
            credits <= credits + CW'(rsp_pop) - CW'(acc_rd);
        end
    end

    assign req_ready = (credits != '0);

    // Stage 0: combinational array read, so a write lands before the next cycle's read.
    assign rd_word = mem[req_addr];

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < NB; i++)
            wr_word[8*i +: 8] = byte_merge(rd_word[8*i +: 8], req_wdata[8*i +: 8], req_be[i]);
    end

    always_ff @(posedge clk) begin
        if (acc_wr) mem[req_addr] <= wr_word;
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [WORDS];
    logic [NB-1:0] rd_par, wr_par;
    logic          rd_err;

    assign rd_par = par_mem[req_addr];

    always_comb begin
        wr_par = rd_par;
        rd_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (req_be[i]) wr_par[i] = byte_parity(req_wdata[8*i +: 8]);
            rd_err = rd_err | (rd_par[i] != byte_parity(rd_word[8*i +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (acc_wr) par_mem[req_addr] <= wr_par;
    end

    assign dat_p0 = {rd_err, rd_word};
`else
    assign dat_p0 = rd_word;
`endif

    assign vld_p0 = acc_rd;

    // Stages 1..READ_LATENCY-1: registered delay line feeding the FIFO.
    if (READ_LATENCY == 1) begin : g_lat1
        assign push_vld = vld_p0;
        assign push_dat = dat_p0;
    end else begin : g_latn
        logic          vld_pn [READ_LATENCY-1];
        logic [FW-1:0] dat_pn [READ_LATENCY-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < READ_LATENCY - 1; s++) vld_pn[s] <= 1'b0;
            end else begin
                vld_pn[0] <= vld_p0;
                for (int s = 1; s < READ_LATENCY - 1; s++) vld_pn[s] <= vld_pn[s-1];
            end
        end

        always_ff @(posedge clk) begin
            dat_pn[0] <= dat_p0;
            for (int s = 1; s < READ_LATENCY - 1; s++) dat_pn[s] <= dat_pn[s-1];
        end

        assign push_vld = vld_pn[READ_LATENCY-2];
        assign push_dat = dat_pn[READ_LATENCY-2];
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_vld),
        .push_data (push_dat),
        .pop       (rsp_pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_rdata = fifo_dout[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
    assign rsp_err   = fifo_dout[DATA_WIDTH];
`endif

endmodule

// File: doc/pipelined_sync_ram.md
PIPELINED_SYNC_RAM -- requirements
Module: pipelined_sync_ram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width, a multiple of 8.
REQ-003 The block SHALL have parameter READ_LATENCY, default 2: accept-to-rsp_valid cycles, legal range 1..4.
REQ-004 The block SHALL have parameter RSP_DEPTH, default 4: response buffer entries, at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: request accepted when high with req_valid.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, ADDR_WIDTH bits: word address.
REQ-011 The block SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port req_be, input, DATA_WIDTH/8 bits: byte enables; bit i enables byte i.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: read data present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: consumer takes the response.
REQ-015 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: parity error; present only with RAM_PARITY_EN.

Function
REQ-017 Memory SHALL hold 2**ADDR_WIDTH words, single port, with at most one request accepted per cycle.
REQ-018 An accepted write SHALL update only the enabled bytes at the next posedge; it produces no response.
REQ-019 An accepted write with req_be all-zero SHALL leave memory unchanged.
REQ-020 An accepted read SHALL enter a READ_LATENCY-deep valid/data pipeline and land in the RSP_DEPTH response FIFO (sub-module sync_fifo).
REQ-021 rsp_valid SHALL equal FIFO not-empty; data SHALL present at READ_LATENCY cycles after accept when the FIFO was empty and rsp_ready held high.
REQ-022 Responses SHALL return in request order, and rsp_rdata SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the newly written bytes.
REQ-024 A credit counter SHALL start at RSP_DEPTH; an accepted read decrements it; a response handshake increments it; both in one cycle leave it unchanged.
REQ-025 req_ready SHALL be (credits != 0) and SHALL NOT depend on req_valid or req_we, so reads and writes both stall at zero credits.
REQ-026 The FIFO SHALL never overflow; full throughput requires RSP_DEPTH >= READ_LATENCY+1, and a smaller depth only lowers throughput.
REQ-027 Address wrap SHALL not exist; the full address range is valid, including all-ones.

Reset
REQ-028 While rst_n is low: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline valids cleared, FIFO empty.
REQ-029 The first clk edge after rst_n deasserts SHALL restore credits to RSP_DEPTH and set req_ready=1.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 A reset mid-operation SHALL discard all in-flight reads and buffered responses; no response emerges for them.

Configuration
REQ-032 With macro RAM_PARITY_EN defined, the block SHALL store one even-parity bit per byte, written with that byte.
REQ-033 With RAM_PARITY_EN defined, a read SHALL check parity and set rsp_err=1 alongside the response if any byte mismatches.
REQ-034 Without RAM_PARITY_EN, the block SHALL have no parity storage and no rsp_err port.

Structure
REQ-035 Package pipelined_sync_ram_pkg SHALL hold MAX_READ_LATENCY=4, the per-byte parity function, and the byte-merge function.
REQ-036 The response buffer SHALL be the one sub-module sync_fifo, parametrised on width and depth.

Verification
REQ-037 Reset, then write 0xDEADBEEF to addr 0x005 with be=4'hF, then read 0x005 -> rsp_valid 2 cycles after accept, rdata=0xDEADBEEF.
REQ-038 Write 0x11223344 to addr 0x00A, then write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
REQ-039 Hold rsp_ready=0 and issue 6 back-to-back reads -> exactly 4 accepted, then req_ready=0; release rsp_ready -> 4 responses arrive in order, then the remaining 2 are accepted.
REQ-040 Write addr 0x3FF, then read 0x3FF the next cycle -> new data returned.
REQ-041 Assert rst_n low with 2 reads in flight -> no rsp_valid after reset and credits=4.
REQ-042 With RAM_PARITY_EN, force a parity-bit flip at addr 0x001 -> the read of 0x001 returns rsp_err=1; other addresses return rsp_err=0.
